// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package mips_fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;

  // One buffered fetch result: byte PC and the word read from memory.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mips_fetch_skid_buf.sv
// Two-entry FIFO of fetch_entry_t sitting between the memory response and
// decode. Flush empties the buffer and wins over a push in the same cycle.
// A push into a full buffer without a simultaneous pop is an overflow and
// trips a simulation assertion; the fetch credit logic must prevent it.
module mips_fetch_skid_buf
  import mips_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;

  logic do_push;
  logic do_pop;
  logic overflow;

  assign do_push  = push && !flush;
  assign do_pop   = pop && (count_q != 2'd0);
  assign overflow = do_push && !do_pop && (count_q == 2'd2);

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; flush only resets the bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '{pc: '0, instr: NOP_INSTR};
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n) !overflow);

endmodule

// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one word read per cycle to a
// synchronous memory (data returns the cycle after ReadPC), buffers results
// in a 2-entry skid buffer and hands (pc, instr) to decode.
// Handshake: decode takes the head entry in any cycle where if_vld && if_rdy;
// if_vld/if_pc/if_instr are registered and never depend on if_rdy.
// Optional feature macro: MIPS_FETCH_PERF_EN adds perf_fetched/perf_stall.
module mips_fetch_stage
  import mips_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  output logic [XLEN-1:0] ReadPC,
  input  logic [XLEN-1:0] Instruction,
  input  logic            redirect_vld,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_vld,
  input  logic            if_rdy,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
`ifdef MIPS_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);
  localparam logic [2:0]      CREDITS = 3'(BUF_DEPTH);

  logic [XLEN-1:0] pc_q;
  logic            req_vld_q;
  logic [XLEN-1:0] req_pc_q;

  logic [1:0]      count;
  fetch_entry_t    head;
  fetch_entry_t    push_data;
  logic            pop;
  logic [2:0]      occupancy;
  logic            issue;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign pop       = if_vld && if_rdy;
  // Slots already claimed once this cycle's pop leaves: buffered + in flight.
  assign occupancy = {1'b0, count} + {2'b00, req_vld_q} - {2'b00, pop};
  assign issue     = fetch_en && !redirect_vld && (occupancy < CREDITS);

  assign push_data = '{pc: req_pc_q, instr: Instruction};

  assign ReadPC   = {2'b00, pc_q[XLEN-1:2]};
  assign if_vld   = (count != 2'd0);
  assign if_pc    = head.pc;
  assign if_instr = head.instr;

  // PC and in-flight request tracking; redirect overrides any issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      req_vld_q <= 1'b0;
      req_pc_q  <= '0;
    end else if (redirect_vld) begin
      pc_q      <= align_pc(redirect_pc);
      req_vld_q <= 1'b0;
    end else if (issue) begin
      pc_q      <= pc_q + PC_STEP;
      req_vld_q <= 1'b1;
      req_pc_q  <= pc_q;
    end else begin
      req_vld_q <= 1'b0;
    end
  end

  mips_fetch_skid_buf u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_vld_q),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_vld),
    .count     (count),
    .head      (head)
  );

`ifdef MIPS_FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  // Free-running event counters, wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      if (pop) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (if_vld && !if_rdy) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Bench for mips_fetch_stage: a directed vector table after reset, hand
// sequences for stall / redirect / reset corners, and a random phase, all
// checked every cycle against a queue-based model of the fetch stage.
module tb_mips_fetch_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (RESET_PC = 0) ----------------
  logic        fetch_en, if_rdy, redirect_vld;
  logic [31:0] redirect_pc, ReadPC, Instruction, if_pc, if_instr;
  logic        if_vld;

  // ---------------- DUT (RESET_PC near wrap) ----------------
  logic [31:0] w_read_pc, w_instruction, w_pc, w_instr;
  logic        w_vld;

`ifdef MIPS_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall, w_perf_fetched, w_perf_stall;
`endif

  mips_fetch_stage u_dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .ReadPC(ReadPC),
    .Instruction(Instruction), .redirect_vld(redirect_vld),
    .redirect_pc(redirect_pc), .if_vld(if_vld), .if_rdy(if_rdy),
    .if_pc(if_pc), .if_instr(if_instr)
`ifdef MIPS_FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  mips_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .fetch_en(1'b1), .ReadPC(w_read_pc),
    .Instruction(w_instruction), .redirect_vld(1'b0),
    .redirect_pc(32'h0), .if_vld(w_vld), .if_rdy(1'b1),
    .if_pc(w_pc), .if_instr(w_instr)
`ifdef MIPS_FETCH_PERF_EN
    , .perf_fetched(w_perf_fetched), .perf_stall(w_perf_stall)
`endif
  );

  // Memory contents by word index: 0..3 hold 0x11..0x44, the rest a hash.
  function automatic logic [31:0] mem_word(input logic [31:0] idx);
    if (idx < 32'd4) return (idx + 32'd1) * 32'h11;
    return (idx * 32'h0001_0003) ^ 32'hC0DE_0000;
  endfunction

  // Synchronous-read memories: data the cycle after the address.
  always @(posedge clk) begin
    Instruction   <= mem_word(ReadPC);
    w_instruction <= mem_word(w_read_pc);
  end

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q[$];     // {pc, instr} entries waiting for decode
  logic [31:0] m_pc;         // next byte PC to fetch
  logic        m_req_vld;    // a read is outstanding
  logic [31:0] m_req_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc      = 32'h0;
    m_req_vld = 1'b0;
    m_req_pc  = 32'h0;
  endtask

  // Called at a falling edge: compare outputs, drive this cycle's inputs,
  // advance the model by one cycle, then wait for the next falling edge.
  task automatic cycle(input logic en, input logic rdy, input logic rv, input logic [31:0] rpc);
    logic pop;
    int   occ;
    check("if_vld", {31'b0, if_vld}, {31'b0, exp_q.size() != 0});
    check("ReadPC", ReadPC, m_pc >> 2);
    if (exp_q.size() != 0) begin
      check("if_pc", if_pc, exp_q[0][63:32]);
      check("if_instr", if_instr, exp_q[0][31:0]);
    end
    fetch_en     = en;
    if_rdy       = rdy;
    redirect_vld = rv;
    redirect_pc  = rpc;
    pop = (exp_q.size() != 0) && rdy;
    occ = exp_q.size() + int'(m_req_vld) - int'(pop);
    if (pop) void'(exp_q.pop_front());
    if (rv) begin
      exp_q.delete();
      m_req_vld = 1'b0;
      m_pc      = {rpc[31:2], 2'b00};
    end else begin
      if (m_req_vld) exp_q.push_back({m_req_pc, mem_word(m_req_pc >> 2)});
      if (en && occ < 2) begin
        m_req_vld = 1'b1;
        m_req_pc  = m_pc;
        m_pc      = m_pc + 32'd4;
      end else begin
        m_req_vld = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        en;
    logic        rdy;
    logic [31:0] exp_readpc;
    logic        exp_vld;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        chk_w;
    logic [31:0] exp_wpc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] rp;

    vecs[0] = '{1'b1, 1'b1, 32'd0, 1'b0, 32'h0, 32'h0,  1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'd1, 1'b0, 32'h0, 32'h0,  1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 32'd2, 1'b1, 32'h0, 32'h11, 1'b1, 32'hFFFF_FFF8};
    vecs[3] = '{1'b1, 1'b1, 32'd3, 1'b1, 32'h4, 32'h22, 1'b1, 32'hFFFF_FFFC};
    vecs[4] = '{1'b1, 1'b1, 32'd4, 1'b1, 32'h8, 32'h33, 1'b1, 32'h0000_0000};
    vecs[5] = '{1'b1, 1'b1, 32'd5, 1'b1, 32'hC, 32'h44, 1'b0, 32'h0};

    fetch_en = 1'b0; if_rdy = 1'b0; redirect_vld = 1'b0; redirect_pc = 32'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);

    // Reset state of both instances.
    check("rst_if_vld", {31'b0, if_vld}, 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_ReadPC", ReadPC, 32'h0);
    check("rst_w_ReadPC", w_read_pc, 32'h3FFF_FFFE);
    check("rst_w_vld", {31'b0, w_vld}, 32'd0);

    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("vec_ReadPC", ReadPC, vecs[i].exp_readpc);
      check("vec_if_vld", {31'b0, if_vld}, {31'b0, vecs[i].exp_vld});
      check("vec_if_pc", if_pc, vecs[i].exp_pc);
      check("vec_if_instr", if_instr, vecs[i].exp_instr);
      if (vecs[i].chk_w) begin
        check("wrap_vld", {31'b0, w_vld}, 32'd1);
        check("wrap_pc", w_pc, vecs[i].exp_wpc);
      end
      cycle(vecs[i].en, vecs[i].rdy, 1'b0, 32'h0);
    end
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Backpressure: buffer fills, ReadPC freezes, nothing lost on release.
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    rp = ReadPC;
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("bp_readpc_hold", ReadPC, rp);
    check("bp_vld_held", {31'b0, if_vld}, 32'd1);
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect to 0x43 mid-stream: drop, then 0x40 three cycles later.
    cycle(1'b1, 1'b1, 1'b1, 32'h43);
    check("redir_vld_drop", {31'b0, if_vld}, 32'd0);
    check("redir_readpc", ReadPC, 32'h10);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_vld_gap", {31'b0, if_vld}, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_vld_back", {31'b0, if_vld}, 32'd1);
    check("redir_pc", if_pc, 32'h40);
    check("redir_instr", if_instr, mem_word(32'h10));
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect together with a pop while the buffer is full.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("full_before_flush", {31'b0, if_vld}, 32'd1);
    cycle(1'b1, 1'b1, 1'b1, 32'h200);
    check("flush_empty", {31'b0, if_vld}, 32'd0);
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // fetch_en low: pending response lands and the buffer drains.
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (5) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("fetch_off_drained", {31'b0, if_vld}, 32'd0);

    // Random traffic.
    repeat (500) begin
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 24) == 0, $urandom);
    end

    // Asynchronous reset while a fetch is in flight.
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_if_vld", {31'b0, if_vld}, 32'd0);
    check("midrst_if_pc", if_pc, 32'h0);
    check("midrst_if_instr", if_instr, 32'h0);
    check("midrst_ReadPC", ReadPC, 32'h0);
    check("midrst_w_ReadPC", w_read_pc, 32'h3FFF_FFFE);
    @(negedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check("postrst_no_stale", {31'b0, if_vld}, 32'd0);
    repeat (20) cycle(1'b1, $urandom_range(0, 1) != 0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
